// File: rtl/priority_encoder_sync.sv
// Registered 8-to-3 priority encoder: sticky request capture, valid/ack offer of the top pending index.
// 1-cycle req-to-valid latency; an offer is held with no preemption until acked, and acks retire one request per cycle.
module priority_encoder_sync #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [7:0] req,
  input  logic       ack,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] code_q;
  logic [7:0] pend_q;

  logic [7:0] clr;
  logic [7:0] set;
  logic [7:0] pend_nxt;
  logic [2:0] sel_code;
  logic       sel_any;

  always_comb begin
    clr = 8'h00;
    if (state_q == OFFER && ack) clr[code_q] = 1'b1;
  end

  assign set      = e ? req : 8'h00;
  // Set is OR-ed in after the clear so a re-asserted request on the acked bit survives.
  assign pend_nxt = (pend_q & ~clr) | set;

  // Scan from lowest to highest priority; the last hit is the winner.
  always_comb begin
    sel_code = 3'd0;
    sel_any  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (pend_nxt[HIGH_FIRST ? n : 7 - n]) begin
        sel_code = HIGH_FIRST ? 3'(n) : 3'(7 - n);
        sel_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      pend_q  <= 8'h00;
    end else begin
      pend_q <= pend_nxt;
      if (!(state_q == OFFER && !ack)) begin
        if (sel_any) begin
          state_q <= OFFER;
          code_q  <= sel_code;
        end else begin
          state_q <= IDLE;
          code_q  <= 3'd0;
        end
      end
    end
  end

  assign {a, b, c} = code_q;
  assign valid     = (state_q == OFFER);
  assign pending   = pend_q;

endmodule

// File: tb/tb_priority_encoder_sync.sv
// Bench for priority_encoder_sync: both priority orders side by side, directed literal checks plus a randomized run against a reference model.
module tb_priority_encoder_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       e = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ack0 = 1'b0;
  logic       ack1 = 1'b0;
  logic       a0, b0, c0, v0;
  logic       a1, b1, c1, v1;
  logic [7:0] p0, p1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  priority_encoder_sync #(.HIGH_FIRST(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .e(e), .req(req), .ack(ack0),
    .a(a0), .b(b0), .c(c0), .valid(v0), .pending(p0)
  );

  priority_encoder_sync #(.HIGH_FIRST(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .e(e), .req(req), .ack(ack1),
    .a(a1), .b(b1), .c(c1), .valid(v1), .pending(p1)
  );

  // Reference model: index 0 is the high-first instance, index 1 the low-first one.
  logic [7:0] m_pend [2] = '{8'h00, 8'h00};
  logic       m_valid[2] = '{1'b0, 1'b0};
  logic [2:0] m_idx  [2] = '{3'd0, 3'd0};

  function automatic int best(input logic [7:0] v, input bit hf);
    for (int n = 0; n < 8; n++) begin
      int i = hf ? 7 - n : n;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k]  = 8'h00;
        m_valid[k] = 1'b0;
        m_idx[k]   = 3'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] nxt;
        logic       ak;
        ak  = (k == 0) ? ack0 : ack1;
        nxt = m_pend[k];
        if (m_valid[k] && ak) nxt[m_idx[k]] = 1'b0;
        if (e) nxt = nxt | req;
        if (!m_valid[k] || ak) begin
          m_valid[k] = (nxt != 8'h00);
          m_idx[k]   = (nxt != 8'h00) ? 3'(best(nxt, k == 0)) : 3'd0;
        end
        m_pend[k] = nxt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi_model", {20'd0, v0, a0, b0, c0, p0}, {20'd0, m_valid[0], m_idx[0], m_pend[0]});
      chk("lo_model", {20'd0, v1, a1, b1, c1, p1}, {20'd0, m_valid[1], m_idx[1], m_pend[1]});
      if (v0) chk("hi_offer_pending", 32'(p0[{a0, b0, c0}]), 32'd1);
      if (v1) chk("lo_offer_pending", 32'(p1[{a1, b1, c1}]), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req = 8'h00; e = 1'b1; ack0 = 1'b1; ack1 = 1'b1;
    repeat (10) tick();
    ack0 = 1'b0; ack1 = 1'b0;
  endtask

  logic [2:0] exp_hi [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
  logic [2:0] exp_lo [4] = '{3'd0, 3'd2, 3'd5, 3'd7};

  initial begin
    // Reset held with all requests active.
    #1 rst_n = 1'b0;
    e = 1'b1; req = 8'hFF;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_hi", {v0, a0, b0, c0, p0}, 12'h000);
    chk("rst_lo", {v1, a1, b1, c1, p1}, 12'h000);
    rst_n = 1'b1;
    tick();
    chk("post_rst_hi", {v0, a0, b0, c0, p0}, {1'b1, 3'b111, 8'hFF});
    chk("post_rst_lo", {v1, a1, b1, c1, p1}, {1'b1, 3'b000, 8'hFF});
    drain();

    // Single request held until acked.
    req = 8'h08;
    tick();
    req = 8'h00;
    chk("single_hi", {v0, a0, b0, c0}, 4'b1011);
    chk("single_lo", {v1, a1, b1, c1}, 4'b1011);
    repeat (5) tick();
    chk("single_hold", {v0, a0, b0, c0}, 4'b1011);
    ack0 = 1'b1; ack1 = 1'b1;
    tick();
    ack0 = 1'b0; ack1 = 1'b0;
    chk("single_retire", {v0, p0, v1, p1}, 18'd0);

    // Back-to-back drain in both priority orders.
    req = 8'hA5; ack0 = 1'b1; ack1 = 1'b1;
    tick();
    req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("drain_hi", {v0, a0, b0, c0}, {1'b1, exp_hi[i]});
      chk("drain_lo", {v1, a1, b1, c1}, {1'b1, exp_lo[i]});
    end
    tick();
    chk("drain_empty", {v0, v1}, 2'b00);
    ack0 = 1'b0; ack1 = 1'b0;

    // No preemption by a later higher-priority request.
    req = 8'h02;
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    tick();
    chk("nopreempt", {v0, a0, b0, c0}, 4'b1001);
    ack0 = 1'b1; ack1 = 1'b1;
    tick();
    ack0 = 1'b0; ack1 = 1'b0;
    chk("nopreempt_next", {v0, a0, b0, c0}, 4'b1111);
    drain();

    // Set wins over the clear of the acked bit.
    req = 8'h10;
    tick();
    chk("setwin_offer", {v0, a0, b0, c0}, 4'b1100);
    ack0 = 1'b1; ack1 = 1'b1;
    tick();
    chk("setwin_keep", {v0, a0, b0, c0, p0}, {1'b1, 3'b100, 8'h10});
    req = 8'h00;
    tick();
    chk("setwin_clear", {v0, p0}, 9'd0);
    ack0 = 1'b0; ack1 = 1'b0;

    // Enable gating, then asynchronous reset mid-offer.
    e = 1'b0; req = 8'hFF;
    repeat (2) tick();
    chk("gate_hi", {v0, p0}, 9'd0);
    chk("gate_lo", {v1, p1}, 9'd0);
    e = 1'b1; req = 8'h10;
    tick();
    chk("pre_arst", {v0, a0, b0, c0}, 4'b1100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", {v0, a0, b0, c0, p0}, 12'h000);
    chk("arst_lo", {v1, a1, b1, c1, p1}, 12'h000);
    tick();
    rst_n = 1'b1;
    req = 8'h00;

    // Randomized traffic, checked every cycle by the model compare.
    for (int n = 0; n < 3000; n++) begin
      e    = ($urandom_range(0, 3) != 0);
      req  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
      ack0 = $urandom_range(0, 1) == 1;
      ack1 = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder_sync.md
Name: priority_encoder_sync

Overview:
- Registered 8-to-3 priority encoder with request capture and a valid/ack handshake; the inverse of the team's 3-to-8 enabled decoder.
- Collects one-hot or multi-hot request lines into sticky pending bits.
- Presents the index of the highest-priority pending request as code bits a (MSB), b, c.
- Retires each request when the consumer acknowledges it.
- Sits upstream of the decoder: its a/b/c/valid can drive that block's a/b/c/e directly, forming a request-to-grant loop.

Parameters:
- HIGH_FIRST, 1: 1 = req[7] highest priority, req[0] lowest; 0 = req[0] highest, req[7] lowest.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- e  input  1  capture enable; when 0, req is ignored (pending bits are kept)
- req  input  8  request lines, bit i = request i, sampled each rising edge
- ack  input  1  consumer accepts the current code; meaningful only when valid=1
- a  output  1  code bit 2 (MSB) of the selected index
- b  output  1  code bit 1
- c  output  1  code bit 0 (LSB)
- valid  output  1  a/b/c hold a pending request index
- pending  output  8  current sticky pending bits, for debug and status

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - pending=8'h00, valid=0, a=b=c=0.
  - All held immediately while rst_n=0.
  - First capture happens on the first rising edge after rst_n rises.
- Per-edge next-state, evaluated in this order:
  1. clr = one-hot of {a,b,c} if (valid && ack), else 0.
  2. set = req if e=1, else 0.
  3. pending_next = (pending & ~clr) | set.
  4. Set wins over clear on the same bit: a re-asserted request on the bit being acked stays pending.
- Output register (state machine with two states, IDLE (valid=0) and OFFER (valid=1)):
  - OFFER and ack=0: hold a/b/c/valid unchanged. No preemption, even if a higher-priority request arrives.
  - OFFER and ack=1, or IDLE: if pending_next != 0, go to OFFER with {a,b,c} = index of the highest-priority set bit of pending_next (per HIGH_FIRST). Otherwise go to IDLE with valid=0 and a=b=c=0.
- Latency and throughput:
  - A request arriving into IDLE produces valid=1 on the same edge that captures it (1 cycle from req assertion).
  - After an ack, the next index is presented on that same edge. No bubble: back-to-back acks retire one request per cycle.
- ack while valid=0 has no effect.
- Requests are level-sampled. A request held high for N cycles is still one pending bit. Once acked, a still-high req line re-pends on that edge (set wins).
- e=0 blocks new captures only; offering and retirement of existing pending bits continue.
- When valid=1, the pending bit addressed by {a,b,c} is always 1.
- No overflow condition exists; at most 8 outstanding requests.
- Reset mid-offer discards all pending bits; no ack is required afterwards.

Test Plan:
- Reset check: hold rst_n=0 with req=8'hFF, e=1 -> pending=00, valid=0, abc=000 throughout. Release rst_n -> next edge valid=1, abc=111, pending=FF.
- Single request: e=1, req=8'h08 for 1 cycle, ack=0 -> valid=1, abc=011, held stable for 5 cycles. Then ack=1 for 1 cycle -> valid=0, pending=00.
- Priority drain: req=8'hA5 for 1 cycle, ack=1 continuously -> codes 111, 101, 010, 000 on consecutive cycles, then valid=0. Repeat with HIGH_FIRST=0 -> 000, 010, 101, 111.
- No preemption: req=8'h02, wait until valid with abc=001, then pulse req=8'h80 with ack=0 -> abc stays 001. Ack -> next cycle abc=111.
- Set-wins collision: offering abc=100 with req[4] held high, ack=1 -> pending[4] stays 1 and abc=100 re-offered. Drop req[4] and ack again -> valid=0.
- Enable gating and async reset: e=0 with req=8'hFF -> pending unchanged, valid stays 0. Then e=1 with req=8'h10, assert rst_n=0 mid-cycle -> outputs clear before the next clock edge.
